serial_adder32: RTL and testbench
=================================

// Module: serial_adder32
// PURPOSE
//  Bit-serial WIDTH-bit adder: one fulladder instance plus a carry flip-flop,
//  LSB first, one bit per clock. Area-cheap alternative to the ripple 32-bit
//  adder, built directly on the fulladder cell (sum, carry_out, a, b, carry_in).
//  Upstream logic hands operands over with a start pulse; downstream sees a done pulse.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2); counter is $clog2(WIDTH) bits
// PORTS
//  clk       in   1      single clock, all state updates on rising edge
//  rst_n     in   1      synchronous, active-low reset
//  start     in   1      request; sampled only when busy=0
//  a         in   WIDTH  operand A, sampled on accepted start
//  b         in   WIDTH  operand B, sampled on accepted start
//  cin       in   1      carry-in, sampled on accepted start
//  busy      out  1      1 while an addition is in progress
//  done      out  1      one-cycle pulse: sum/cout/overflow just updated
//  sum       out  WIDTH  result, held until next completion
//  cout      out  1      unsigned carry out of MSB, held
//  overflow  out  1      signed overflow (carry into MSB ^ carry out), held
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, sum, cout, overflow,
//    shift regs, carry reg, counter all 0. Reset wins over every other input.
//  - FSM: IDLE, RUN. No other states.
//  - IDLE & start=1 at edge E0: load a_sh<=a, b_sh<=b, c_reg<=cin, cnt<=0,
//    state<=RUN, busy<=1. start=0: stay IDLE.
//  - RUN, every edge: fulladder inputs a_sh[0], b_sh[0], c_reg;
//    s_sh<={fa_sum, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1;
//    c_reg<=fa_cout; cnt<=cnt+1.
//  - RUN with cnt==WIDTH-1 (edge E_WIDTH): sum<={fa_sum, s_sh[WIDTH-1:1]},
//    cout<=fa_cout, overflow<=fa_cout^c_reg, done<=1, busy<=0, state<=IDLE.
//  - Latency: done high in the cycle after E_WIDTH, i.e. WIDTH cycles after the
//    start edge; throughput one add per WIDTH cycles (back-to-back allowed).
//  - done is high exactly one cycle; otherwise 0.
//  - start while busy=1: ignored, no effect on operands or result.
//  - start in the done cycle (state=IDLE): accepted normally; done still falls
//    next cycle; old sum/cout/overflow held until new completion.
//  - a, b, cin changes after the accepted start have no effect.
//  - Reset mid-RUN: operation abandoned, no done pulse, all outputs 0.
//  - Arithmetic: {cout,sum} == a + b + cin mod 2^(WIDTH+1); overflow set iff
//    a, b same sign and sum sign differs.
// TESTING
//  1. rst_n=0 two cycles, start=1 held -> busy=0, done=0, sum=0, cout=0,
//     overflow=0; no operation begins.
//  2. a=0x00000005, b=0x00000003, cin=0, start 1 cycle -> done exactly 32
//     cycles later, sum=0x00000008, cout=0, overflow=0; busy high 32 cycles.
//  3. a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, overflow=0.
//  4. a=0x7FFFFFFF, b=0x00000000, cin=1 -> sum=0x80000000, cout=0, overflow=1.
//  5. start a=1,b=2; re-pulse start at cycle 5 with a=0xF0,b=0x0F -> result 3
//     only; then start a=0x10,b=0x20 in done cycle -> sum=3 held, then 0x30
//     with done 32 cycles after second accepted start.
//  6. start a=0x12345678,b=0x11111111; rst_n=0 at cycle 10 -> busy=0, no done,
//     outputs 0; following add a=0x12345678,b=0x11111111 -> sum=0x23456789.

Source files
------------

// File: rtl/serial_adder32.sv
// Bit-serial adder: one full-adder cell plus a carry register, LSB first, one bit per clock.
// Operands are captured on an accepted start pulse; completion is signalled with a one-cycle done pulse.

module fulladder (
    output logic sum,
    output logic carry_out,
    input  logic a,
    input  logic b,
    input  logic carry_in
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 result bits need storage; the newest bit comes straight from the cell.
    logic [WIDTH-2:0] s_sh;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] s_next;

    fulladder u_fa (
        .sum       (fa_sum),
        .carry_out (fa_cout),
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .carry_in  (c_reg)
    );

    assign s_next = {fa_sum, s_sh};

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            c_reg    <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c_reg <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_sh  <= s_next[WIDTH-1:1];
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    c_reg <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum      <= s_next;
                        cout     <= fa_cout;
                        overflow <= fa_cout ^ c_reg;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder32.sv
// Directed self-checking bench for serial_adder32: reset, arithmetic corners,
// ignored restart while busy, start in the done cycle, and reset mid-operation.

module tb_serial_adder32;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder32 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after the accepting edge; returns edges until done and busy samples seen.
    task automatic wait_done(input string tag, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic do_add(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        int busy_n;
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        step();
        start = 1'b0;
        // Operand changes after acceptance must not matter
        a     = ~av;
        b     = ~bv;
        cin   = ~ci;
        wait_done(tag, lat, busy_n);
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(overflow), 64'(eo));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        step();
        check({tag, "_done_falls"}, 64'(done), 64'd0);
        check({tag, "_sum_held"}, 64'(sum), 64'(es));
    endtask

    initial begin
        int lat;
        int busy_n;
        logic done_seen;

        // Reset with start held high
        rst_n = 1'b0;
        start = 1'b1;
        a     = 32'h5;
        b     = 32'h3;
        cin   = 1'b0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        check("rst_no_op", 64'(busy), 64'd0);

        do_add("add_5_3", 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0);
        do_add("add_carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        do_add("add_ovf", 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        do_add("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
        do_add("add_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Restart while busy is ignored
        a     = 32'h1;
        b     = 32'h2;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        a     = 32'hF0;
        b     = 32'h0F;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ignore_busy", 64'(busy), 64'd1);
        wait_done("ignore", lat, busy_n);
        check("ignore_latency", 64'(lat), 64'd27);
        check("ignore_sum", 64'(sum), 64'd3);

        // Start accepted in the done cycle
        a     = 32'h10;
        b     = 32'h20;
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_done_falls", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_sum_held", 64'(sum), 64'd3);
        wait_done("b2b", lat, busy_n);
        check("b2b_latency", 64'(lat), 64'd32);
        check("b2b_sum", 64'(sum), 64'h30);
        step();

        // Reset mid-operation
        a     = 32'h1234_5678;
        b     = 32'h1111_1111;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        step();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            done_seen = done_seen | done;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        do_add("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
